// File: rtl/writeback_stage.sv
// Writeback stage of the 5-stage pipeline.
// Holds the MEM/WB latch and drives the register-file write port.
// Tracks instruction retirement and owns the sticky processor halt.
// Optional statistics counters are enabled by defining WB_STATS_EN.
// With WB_STATS_EN defined, ret_count and stall_count exist and saturate at all-ones.

package writeback_pkg;
  typedef struct packed {
    logic        valid;
    logic        RegWen;
    logic [4:0]  wsel;
    logic        MemToReg;
    logic        JAL;
    logic        halt;
    logic [31:0] dmemload;
    logic [31:0] ALUOut;
    logic [31:0] npc;
  } memory_t;
endpackage

module writeback_stage
  import writeback_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             freeze,
  input  logic             flush,
  input  memory_t          memory_p,
  output logic             WEN,
  output logic [4:0]       wsel,
  output logic [31:0]      wdat,
  output logic             halt,
  output logic             retired
`ifdef WB_STATS_EN
  ,
  output logic [CNT_W-1:0] ret_count,
  output logic [CNT_W-1:0] stall_count
`endif
);

  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

  state_t  state;
  memory_t lat;
  logic    fresh;
  logic    advance;
  logic    running;
  logic    act;

  assign running = (state == RUN);
  assign advance = (ihit | dhit) & ~freeze & running;

  // The latched instruction is acted on only in the first cycle after it loads.
  assign act = fresh & lat.valid & running;

  // MEM/WB latch; fresh marks the first cycle after a load so each instruction acts once
  always_ff @(posedge CLK) begin
    if (RST) begin
      lat   <= '0;
      fresh <= 1'b0;
    end else begin
      fresh <= advance;
      if (advance) lat <= flush ? '0 : memory_p;
    end
  end

  // Halt FSM: a retiring halt instruction parks the stage until reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= RUN;
    end else if (state == RUN && act && lat.halt) begin
      state <= HALTED;
    end
  end

  // Regfile write value, JAL link address wins over load data over ALU result
  always_comb begin
    wdat = lat.ALUOut;
    if (lat.JAL)           wdat = lat.npc;
    else if (lat.MemToReg) wdat = lat.dmemload;
  end

  assign wsel    = lat.wsel;
  assign retired = act;
  // The halt instruction never writes back; register 0 is hardwired.
  assign WEN     = act & lat.RegWen & (lat.wsel != 5'd0) & ~lat.halt;
  // Halt is visible in the halt instruction's own retire cycle, then held by the FSM.
  assign halt    = (state == HALTED) | (act & lat.halt);

`ifdef WB_STATS_EN
  // Saturating statistics, both frozen once halted
  always_ff @(posedge CLK) begin
    if (RST) begin
      ret_count   <= '0;
      stall_count <= '0;
    end else if (running) begin
      if (act && ret_count != '1)         ret_count   <= ret_count + 1'b1;
      if (!advance && stall_count != '1)  stall_count <= stall_count + 1'b1;
    end
  end
`else
  // Counter width only matters when statistics are built in.
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: directed steps followed by a randomized run,
// all checked against a behavioural model of the stage.
module tb_writeback_stage;
  import writeback_pkg::*;

  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic        CLK = 1'b0;
  logic        RST, ihit, dhit, freeze, flush;
  memory_t     memory_p;
  logic        WEN, halt, retired;
  logic [4:0]  wsel;
  logic [31:0] wdat;
`ifdef WB_STATS_EN
  logic [CNT_W-1:0] ret_count, stall_count;
`endif

  writeback_stage #(.CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .freeze(freeze), .flush(flush),
    .memory_p(memory_p), .WEN(WEN), .wsel(wsel), .wdat(wdat), .halt(halt),
    .retired(retired)
`ifdef WB_STATS_EN
    , .ret_count(ret_count), .stall_count(stall_count)
`endif
  );

  always #5 CLK = ~CLK;

  // behavioural model: the instruction currently held, whether it is new, halted flag
  memory_t m_instr;
  bit      m_new, m_halted;
  int      m_ret, m_stall;
  int      cmp = 0, mis = 0;

  function automatic memory_t mk(bit v, bit rw, logic [4:0] ws, bit m2r, bit jal, bit h,
                                 logic [31:0] dl, logic [31:0] alu, logic [31:0] npc);
    memory_t m;
    m.valid = v; m.RegWen = rw; m.wsel = ws; m.MemToReg = m2r; m.JAL = jal; m.halt = h;
    m.dmemload = dl; m.ALUOut = alu; m.npc = npc;
    return m;
  endfunction

  task automatic drive(bit r, bit ih, bit dh, bit fr, bit fl, memory_t mp);
    RST = r; ihit = ih; dhit = dh; freeze = fr; flush = fl; memory_p = mp;
  endtask

  // one clock edge; the model takes the same inputs the DUT saw
  task automatic tick();
    bit moves, acting;
    @(posedge CLK);
    if (RST) begin
      m_instr = '0; m_new = 0; m_halted = 0; m_ret = 0; m_stall = 0;
    end else begin
      moves  = (ihit || dhit) && !freeze && !m_halted;
      acting = m_new && m_instr.valid && !m_halted;
      if (!m_halted) begin
        if (acting && m_ret < CMAX)  m_ret++;
        if (!moves && m_stall < CMAX) m_stall++;
      end
      if (acting && m_instr.halt) m_halted = 1;
      if (moves) m_instr = flush ? memory_t'('0) : memory_p;
      m_new = moves;
    end
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    cmp++;
    assert (obs === exp) else begin
      mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string where);
    bit          e_ret, e_wen, e_halt;
    logic [31:0] e_dat;
    e_ret  = m_new && m_instr.valid && !m_halted;
    e_wen  = e_ret && m_instr.RegWen && m_instr.wsel != 0 && !m_instr.halt;
    e_halt = m_halted || (e_ret && m_instr.halt);
    e_dat  = m_instr.JAL ? m_instr.npc : (m_instr.MemToReg ? m_instr.dmemload : m_instr.ALUOut);
    chk({where, ".WEN"},     32'(WEN),     32'(e_wen));
    chk({where, ".retired"}, 32'(retired), 32'(e_ret));
    chk({where, ".halt"},    32'(halt),    32'(e_halt));
    chk({where, ".wsel"},    32'(wsel),    32'(m_instr.wsel));
    chk({where, ".wdat"},    wdat,         e_dat);
`ifdef WB_STATS_EN
    chk({where, ".ret_count"},   32'(ret_count),   m_ret);
    chk({where, ".stall_count"}, 32'(stall_count), m_stall);
`endif
  endtask

  memory_t i_alu, i_ld, i_jal, i_r0, i_halt, i_other, bub;

  initial begin
    bub     = '0;
    i_alu   = mk(1, 1, 5, 0, 0, 0, 32'h0, 32'h1234, 32'h0);
    i_ld    = mk(1, 1, 7, 1, 0, 0, 32'hDEAD, 32'h1111, 32'h2222);
    i_jal   = mk(1, 1, 31, 1, 1, 0, 32'hDEAD, 32'h1111, 32'h40);
    i_r0    = mk(1, 1, 0, 0, 0, 0, 32'h0, 32'h5555, 32'h0);
    i_halt  = mk(1, 1, 3, 0, 0, 1, 32'h0, 32'h9999, 32'h0);
    i_other = mk(1, 1, 9, 0, 0, 0, 32'h0, 32'h7777, 32'h0);

    // 1: reset for two cycles
    drive(1, 0, 0, 0, 0, bub);
    tick(); tick();
    check_all("reset");
    chk("reset.WEN_const", 32'(WEN), 0);
    chk("reset.wdat_const", wdat, 0);

    // 2: ALU result write
    drive(0, 1, 0, 0, 0, i_alu);
    tick(); check_all("alu");
    chk("alu.wdat_const", wdat, 32'h1234);
    chk("alu.WEN_const", 32'(WEN), 1);

    // 3: frozen for three cycles, only one WEN
    drive(0, 1, 0, 1, 0, i_alu);
    for (int i = 0; i < 3; i++) begin
      tick(); check_all("freeze");
      chk("freeze.WEN_const", 32'(WEN), 0);
    end
`ifdef WB_STATS_EN
    chk("freeze.stall_const", 32'(stall_count), 3);
`endif

    // 4: load data, then JAL overriding MemToReg
    drive(0, 0, 1, 0, 0, i_ld);
    tick(); check_all("load");
    chk("load.wdat_const", wdat, 32'hDEAD);
    drive(0, 1, 0, 0, 0, i_jal);
    tick(); check_all("jal");
    chk("jal.wdat_const", wdat, 32'h40);

    // 5: r0 destination retires without write; flush inserts a bubble
    drive(0, 1, 0, 0, 0, i_r0);
    tick(); check_all("r0");
    chk("r0.WEN_const", 32'(WEN), 0);
    chk("r0.retired_const", 32'(retired), 1);
    drive(0, 1, 0, 0, 1, i_alu);
    tick(); check_all("flush");
    chk("flush.retired_const", 32'(retired), 0);
    drive(0, 0, 0, 0, 1, i_alu);
    tick(); check_all("flush_noadv");

    // 6: halt instruction, later instructions ignored, reset clears
    drive(0, 1, 0, 0, 0, i_halt);
    tick(); check_all("halt");
    chk("halt.WEN_const", 32'(WEN), 0);
    chk("halt.halt_const", 32'(halt), 1);
    drive(0, 1, 1, 0, 0, i_other);
    for (int i = 0; i < 4; i++) begin
      tick(); check_all("halted");
      chk("halted.retired_const", 32'(retired), 0);
    end
    drive(1, 1, 0, 0, 0, i_other);
    tick(); check_all("halt_reset");
    chk("halt_reset.halt_const", 32'(halt), 0);

    // randomized run with occasional halts and resets
    for (int n = 0; n < 600; n++) begin
      memory_t r;
      r.valid    = ($urandom_range(0, 7) != 0);
      r.RegWen   = $urandom_range(0, 1);
      r.wsel     = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
      r.MemToReg = $urandom_range(0, 1);
      r.JAL      = ($urandom_range(0, 3) == 0);
      r.halt     = ($urandom_range(0, 24) == 0);
      r.dmemload = $urandom; r.ALUOut = $urandom; r.npc = $urandom;
      drive(($urandom_range(0, 59) == 0), ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 6) == 0), r);
      tick(); check_all("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
    $finish;
  end
endmodule
